// File: rtl/bht_train_sched.sv
// Port arbiter and RMW sequencer for the single-ported 2-bit-counter branch-history table.
// Optional statistics counters are enabled with `define BHT_SCHED_STATS_EN.
module bht_train_sched #(
  parameter int IDX_W        = 8,
  parameter int DEPTH_W      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             lookup_valid,
  input  logic [IDX_W-1:0] lookup_idx,
  output logic             lookup_ready,
  output logic             pred_valid,
  output logic             pred_taken,
  input  logic             train_valid,
  input  logic [IDX_W-1:0] train_idx,
  input  logic             train_taken,
  output logic             train_ready,
  output logic             tbl_en,
  output logic             tbl_we,
  output logic [IDX_W-1:0] tbl_addr,
  output logic [1:0]       tbl_wdata,
  input  logic [1:0]       tbl_rdata,
  output logic [1:0]       state_dbg
`ifdef BHT_SCHED_STATS_EN
  ,
  output logic [31:0]      stat_trains,
  output logic [31:0]      stat_forced
`endif
);

  // Handshakes: a push happens when train_valid & train_ready & rdy; a lookup is
  // granted when lookup_valid & lookup_ready, and its prediction appears next cycle.

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RD_WAIT = 2'd1, S_WR = 2'd2} state_e;

  localparam int DEPTH = 1 << DEPTH_W;
  localparam int SW    = $clog2(STARVE_LIMIT + 1);

  state_e              state_q, state_d;
  logic [DEPTH_W:0]    wr_ptr_q, wr_ptr_d;
  logic [DEPTH_W:0]    rd_ptr_q, rd_ptr_d;
  logic [SW-1:0]       starve_q, starve_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                pred_valid_q;
  logic [IDX_W:0]      fifo_mem [DEPTH];

  logic                empty, full, push, pop;
  logic                train_act, force_slot, lookup_grant, port_free;
  logic [IDX_W-1:0]    head_idx;
  logic                head_taken;

  function automatic logic [1:0] upd(input logic [1:0] c, input logic t);
    if (t) return (c == 2'b11) ? c : c + 2'd1;
    else   return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[DEPTH_W] != rd_ptr_q[DEPTH_W]) &&
                 (wr_ptr_q[DEPTH_W-1:0] == rd_ptr_q[DEPTH_W-1:0]);
  assign {head_idx, head_taken} = fifo_mem[rd_ptr_q[DEPTH_W-1:0]];

  // A train action is pending when IDLE holds queued work or WR waits for the port.
  assign train_act    = ((state_q == S_IDLE) && !empty) || (state_q == S_WR);
  assign force_slot   = (starve_q == SW'(STARVE_LIMIT)) && train_act;
  assign lookup_ready = rdy && !force_slot;
  assign lookup_grant = lookup_valid && lookup_ready;
  assign port_free    = rdy && !lookup_grant;
  assign push         = train_valid && !full && rdy;
  assign train_ready  = !full;
  assign pred_valid   = pred_valid_q;
  assign pred_taken   = pred_valid_q && tbl_rdata[1];
  assign state_dbg    = state_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pop       = 1'b0;
    tbl_en    = 1'b0;
    tbl_we    = 1'b0;
    tbl_addr  = '0;
    tbl_wdata = 2'b00;
    if (lookup_grant) begin
      tbl_en   = 1'b1;
      tbl_addr = lookup_idx;
    end
    case (state_q)
      S_IDLE: begin
        if (!empty && port_free) begin
          tbl_en   = 1'b1;
          tbl_addr = head_idx;
          state_d  = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (rdy) begin
          cnt_d   = tbl_rdata;
          state_d = S_WR;
        end
      end
      S_WR: begin
        if (port_free) begin
          tbl_en    = 1'b1;
          tbl_we    = 1'b1;
          tbl_addr  = head_idx;
          tbl_wdata = upd(cnt_q, head_taken);
          pop       = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    starve_d = starve_q;
    if (rdy) begin
      if (train_act && lookup_grant) starve_d = starve_q + 1'b1;
      else if (train_act || empty)   starve_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      starve_q     <= '0;
      cnt_q        <= 2'b00;
      pred_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      starve_q     <= starve_d;
      cnt_q        <= cnt_d;
      pred_valid_q <= lookup_grant;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[DEPTH_W-1:0]] <= {train_idx, train_taken};
  end

`ifdef BHT_SCHED_STATS_EN
  logic [31:0] stat_trains_q, stat_forced_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_trains_q <= 32'd0;
      stat_forced_q <= 32'd0;
    end else begin
      if (pop)                stat_trains_q <= stat_trains_q + 32'd1;
      if (force_slot && rdy)  stat_forced_q <= stat_forced_q + 32'd1;
    end
  end

  assign stat_trains = stat_trains_q;
  assign stat_forced = stat_forced_q;
`endif

endmodule

// File: tb/tb_bht_train_sched.sv
// Directed bench for bht_train_sched: lookups, RMW training, saturation, FIFO full,
// starvation forcing, rdy freeze and reset during an in-flight read.
module tb_bht_train_sched;

  logic       clk;
  logic       rst;
  logic       rdy;
  logic       lookup_valid;
  logic [7:0] lookup_idx;
  logic       lookup_ready;
  logic       pred_valid;
  logic       pred_taken;
  logic       train_valid;
  logic [7:0] train_idx;
  logic       train_taken;
  logic       train_ready;
  logic       tbl_en;
  logic       tbl_we;
  logic [7:0] tbl_addr;
  logic [1:0] tbl_wdata;
  logic [1:0] tbl_rdata;
  logic [1:0] state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  bht_train_sched #(.IDX_W(8), .DEPTH_W(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .lookup_valid(lookup_valid), .lookup_idx(lookup_idx), .lookup_ready(lookup_ready),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .train_valid(train_valid), .train_idx(train_idx), .train_taken(train_taken),
    .train_ready(train_ready),
    .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
    .tbl_rdata(tbl_rdata), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push one training entry with the port otherwise idle and follow its RMW.
  task automatic run_train(input logic [7:0] idx, input logic tk,
                           input logic [1:0] rd, input logic [1:0] expw);
    tick();
    train_valid = 1'b1; train_idx = idx; train_taken = tk;
    #1;
    chk("rt_push_ready", train_ready, 1);
    chk("rt_push_noen", tbl_en, 0);
    tick();
    train_valid = 1'b0;
    #1;
    chk("rt_rd_en", tbl_en, 1);
    chk("rt_rd_we", tbl_we, 0);
    chk("rt_rd_addr", tbl_addr, idx);
    tick();
    tbl_rdata = rd;
    #1;
    chk("rt_wait_state", state_dbg, 1);
    chk("rt_wait_noen", tbl_en, 0);
    tick();
    #1;
    chk("rt_wr_en", tbl_en, 1);
    chk("rt_wr_we", tbl_we, 1);
    chk("rt_wr_addr", tbl_addr, idx);
    chk("rt_wr_data", tbl_wdata, expw);
    tick();
    #1;
    chk("rt_done_state", state_dbg, 0);
    chk("rt_done_noen", tbl_en, 0);
  endtask

  initial begin
    logic [7:0] q_idx [4];
    logic [1:0] q_wd  [4];
    q_idx[0] = 8'h10; q_idx[1] = 8'h11; q_idx[2] = 8'h12; q_idx[3] = 8'h13;
    q_wd[0]  = 2'b10; q_wd[1]  = 2'b00; q_wd[2]  = 2'b10; q_wd[3]  = 2'b10;

    rst = 1'b0; rdy = 1'b1;
    lookup_valid = 1'b0; lookup_idx = 8'h00;
    train_valid = 1'b0; train_idx = 8'h00; train_taken = 1'b0;
    tbl_rdata = 2'b00;
    #1;
    chk("rst_pred_valid", pred_valid, 0);
    chk("rst_train_ready", train_ready, 1);
    chk("rst_tbl_en", tbl_en, 0);
    chk("rst_tbl_we", tbl_we, 0);
    chk("rst_state", state_dbg, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Plain lookup
    tick();
    lookup_valid = 1'b1; lookup_idx = 8'h05;
    #1;
    chk("lk_ready", lookup_ready, 1);
    chk("lk_en", tbl_en, 1);
    chk("lk_we", tbl_we, 0);
    chk("lk_addr", tbl_addr, 8'h05);
    tick();
    lookup_valid = 1'b0; tbl_rdata = 2'b10;
    #1;
    chk("lk_pred_valid", pred_valid, 1);
    chk("lk_pred_taken", pred_taken, 1);
    chk("lk_idle_en", tbl_en, 0);
    tick();
    #1;
    chk("lk_pred_drop", pred_valid, 0);

    // Basic training and saturation
    run_train(8'h05, 1'b1, 2'b01, 2'b10);
    run_train(8'h06, 1'b1, 2'b11, 2'b11);
    run_train(8'h07, 1'b0, 2'b00, 2'b00);
    run_train(8'h08, 1'b0, 2'b10, 2'b01);

    // Fill the FIFO while lookups hold the port; the 5th push must be dropped
    tick();
    lookup_valid = 1'b1; lookup_idx = 8'h40;
    train_valid = 1'b1; train_idx = 8'h10; train_taken = 1'b1;
    #1;
    chk("full_c0_lkready", lookup_ready, 1);
    chk("full_c0_addr", tbl_addr, 8'h40);
    tick();
    train_idx = 8'h11; train_taken = 1'b0;
    #1;
    chk("full_c1_lkready", lookup_ready, 1);
    chk("full_c1_we", tbl_we, 0);
    tick();
    train_idx = 8'h12; train_taken = 1'b1;
    tick();
    train_idx = 8'h13; train_taken = 1'b1;
    #1;
    chk("full_c3_tready", train_ready, 1);
    tick();
    train_idx = 8'h14; train_taken = 1'b0;
    #1;
    chk("full_c4_tready", train_ready, 0);
    chk("full_c4_lkready", lookup_ready, 1);
    tick();
    train_valid = 1'b0;
    #1;
    chk("full_force_lkready", lookup_ready, 0);
    chk("full_force_en", tbl_en, 1);
    chk("full_force_we", tbl_we, 0);
    chk("full_force_addr", tbl_addr, 8'h10);
    tbl_rdata = 2'b01;
    for (int e = 0; e < 4; e++) begin
      if (e > 0) begin
        tick();
        #1;
        chk("full_rd_addr", tbl_addr, q_idx[e]);
        chk("full_rd_we", tbl_we, 0);
        chk("full_rd_tready", train_ready, 1);
      end
      tick();
      lookup_valid = 1'b0;
      #1;
      chk("full_wait_noen", tbl_en, 0);
      if (e == 0) chk("full_wait_pred", pred_valid, 0);
      tick();
      #1;
      chk("full_wr_we", tbl_we, 1);
      chk("full_wr_addr", tbl_addr, q_idx[e]);
      chk("full_wr_data", tbl_wdata, q_wd[e]);
    end
    tick();
    #1;
    chk("full_drained_state", state_dbg, 0);
    chk("full_drained_en", tbl_en, 0);

    // Starvation forcing under continuous lookups
    tick();
    lookup_valid = 1'b1; lookup_idx = 8'h55;
    train_valid = 1'b1; train_idx = 8'h60; train_taken = 1'b0;
    #1;
    chk("stv_t0_lkready", lookup_ready, 1);
    tick();
    train_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) tick();
      #1;
      chk("stv_blk_lkready", lookup_ready, 1);
      chk("stv_blk_addr", tbl_addr, 8'h55);
    end
    tick();
    #1;
    chk("stv_rd_lkready", lookup_ready, 0);
    chk("stv_rd_we", tbl_we, 0);
    chk("stv_rd_addr", tbl_addr, 8'h60);
    tick();
    tbl_rdata = 2'b10;
    #1;
    chk("stv_wait_lkready", lookup_ready, 1);
    chk("stv_wait_addr", tbl_addr, 8'h55);
    chk("stv_wait_state", state_dbg, 1);
    chk("stv_wait_pred", pred_valid, 0);
    for (int i = 7; i <= 10; i++) begin
      tick();
      #1;
      chk("stv_wrblk_lkready", lookup_ready, 1);
      chk("stv_wrblk_we", tbl_we, 0);
      chk("stv_wrblk_state", state_dbg, 2);
    end
    tick();
    #1;
    chk("stv_wr_lkready", lookup_ready, 0);
    chk("stv_wr_we", tbl_we, 1);
    chk("stv_wr_addr", tbl_addr, 8'h60);
    chk("stv_wr_data", tbl_wdata, 2'b01);
    tick();
    lookup_valid = 1'b0;
    #1;
    chk("stv_done_state", state_dbg, 0);
    chk("stv_done_pred", pred_valid, 0);

    // rdy low for three cycles while in WR
    tick();
    train_valid = 1'b1; train_idx = 8'h20; train_taken = 1'b1;
    tick();
    train_valid = 1'b0;
    tick();
    tbl_rdata = 2'b00;
    tick();
    rdy = 1'b0; lookup_valid = 1'b1; lookup_idx = 8'h77;
    train_valid = 1'b1; train_idx = 8'h70; tbl_rdata = 2'b11;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      #1;
      chk("rdy_frz_en", tbl_en, 0);
      chk("rdy_frz_lkready", lookup_ready, 0);
      chk("rdy_frz_state", state_dbg, 2);
    end
    tick();
    rdy = 1'b1; lookup_valid = 1'b0; train_valid = 1'b0;
    #1;
    chk("rdy_pred", pred_valid, 0);
    chk("rdy_wr_we", tbl_we, 1);
    chk("rdy_wr_addr", tbl_addr, 8'h20);
    chk("rdy_wr_data", tbl_wdata, 2'b01);
    tick();
    #1;
    chk("rdy_done_state", state_dbg, 0);
    chk("rdy_done_en", tbl_en, 0);

    // Reset during RD_WAIT discards the RMW
    tick();
    train_valid = 1'b1; train_idx = 8'h30; train_taken = 1'b1;
    tick();
    train_valid = 1'b0;
    tick();
    tbl_rdata = 2'b10;
    rst = 1'b0;
    #1;
    chk("mrst_state", state_dbg, 0);
    chk("mrst_en", tbl_en, 0);
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      chk("mrst_noen", tbl_en, 0);
      chk("mrst_idle", state_dbg, 0);
    end
    chk("mrst_tready", train_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bht_train_sched.md
Name: bht_train_sched

Overview:
- Arbiter and sequencer for the single-ported branch-history table (2-bit saturating counters) behind the predictor.
- Grants the table port each cycle either to a fetch-side lookup or to a queued training read-modify-write (RMW) from RS.
- Training results are buffered in a FIFO so RS never blocks on table contention.
- Sits between Fetcher/predictor logic, RS train outputs, and the BHT RAM.

Parameters:
IDX_W, 8, table index width (2^IDX_W entries)
DEPTH_W, 2, train FIFO depth = 2^DEPTH_W
STARVE_LIMIT, 4, consecutive train-blocked cycles before training is forced one port slot

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
rdy  in  1  global ready; low freezes all state, tbl_en=0
lookup_valid  in  1  fetch requests counter read
lookup_idx  in  IDX_W  lookup index
lookup_ready  out  1  lookup granted this cycle (combinational)
pred_valid  out  1  prediction valid (cycle after grant)
pred_taken  out  1  predicted taken = tbl_rdata[1] when pred_valid
train_valid  in  1  RS training result valid
train_idx  in  IDX_W  index to train
train_taken  in  1  actual branch outcome
train_ready  out  1  FIFO not full
tbl_en  out  1  table port enable
tbl_we  out  1  table write enable
tbl_addr  out  IDX_W  table address
tbl_wdata  out  2  counter write data
tbl_rdata  in  2  read data, valid one cycle after read issue

Behaviour:
- Reset (rst=0, async): FIFO empty, FSM=IDLE, starve_cnt=0, pred_valid=0, train_ready=1, tbl_en=0, tbl_we=0. Table contents are not touched by this block.
- Push: train_valid & train_ready & rdy writes {idx, taken} at tail.
- train_ready = !full. Push is not accepted when full, even if a pop occurs the same cycle.
- force = (starve_cnt == STARVE_LIMIT) & FSM in {IDLE with FIFO non-empty, WR}.
- lookup_ready = rdy & !force.
- Lookup grant (lookup_valid & lookup_ready) drives tbl_en=1, tbl_we=0, tbl_addr=lookup_idx. Next cycle pred_valid=1. Otherwise pred_valid=0 next cycle.
- FSM:
  - IDLE: if FIFO non-empty and port free (no lookup grant): issue read of head idx, go RD_WAIT. Else stay.
  - RD_WAIT: port unused by RMW (lookups may use it). Capture tbl_rdata into cnt_q, go WR.
  - WR: if port free: tbl_en=1, tbl_we=1, tbl_addr=head idx, tbl_wdata=upd(cnt_q), pop head, go IDLE. Else hold in WR.
- upd(c): taken -> min(c+1, 3); not taken -> max(c-1, 0). 2-bit saturation, no wrap.
- starve_cnt increments each cycle a train action (IDLE non-empty or WR) loses the port to a lookup. It clears when the train action proceeds or the FIFO empties.
- At force, lookup_ready=0 for exactly that cycle and the train action takes the port.
- Same-index lookup during an in-flight RMW returns the pre-update value; no forwarding.
- rdy=0: no push, no pop, no FSM transition, counters hold, tbl_en=0, lookup_ready=0, pred_valid=0 next cycle.
- Reset asserted mid-RMW: in-flight and queued training is discarded; table is left unmodified or fully written (never a partial write).

Optional Feature:
BHT_SCHED_STATS_EN
- Defined: adds output stat_trains[31:0], incremented on each completed WR, and output stat_forced[31:0], incremented on each forced slot. Both wrap at 2^32 and reset to 0.
- Undefined: neither port exists; behaviour is otherwise identical.

Test Plan:
- Reset, then lookup idx 0x05 with tbl_rdata=2'b10 -> lookup_ready=1; next cycle pred_valid=1, pred_taken=1; tbl_en never has tbl_we=1.
- Push train {0x05, taken} with no lookups, table value 2'b01 -> read at cycle+1, write 0x05 <= 2'b10 at cycle+3; FIFO empty after.
- Saturation: train taken on counter 3 -> writes 3; train not-taken on counter 0 -> writes 0.
- Push 4 trains (DEPTH_W=2) while lookups hold the port -> train_ready=0 after 4th; 5th push ignored; all 4 writes occur in order once the port frees.
- Continuous lookup_valid=1 with a pending train, STARVE_LIMIT=4 -> after 4 blocked cycles lookup_ready=0 for one cycle, RMW advances; repeat until pop.
- Drop rdy for 3 cycles while in WR -> no table activity, state held; write completes the first free cycle after rdy=1. Assert rst=0 mid-RD_WAIT -> FIFO empty, no write issued.
